game_session_ctrl: RTL and testbench

Parametrised match-session controller for the pong game server: sequences ready → countdown → play → pause → game-over, generates the gated physics-step enable (frame_tick) and the one-second match clock, and supports an optional overtime period. It sits between the debounced/one-pulsed start button and score logic on one side, and the step engine, VGA overlay and seven-segment timer on the other.

---
 rtl/game_session_pkg.sv | 21 ++
 rtl/game_session_ctrl_if.sv | 33 +++
 rtl/game_session_ctrl_tick_prescaler.sv | 35 +++
 rtl/game_session_ctrl.sv | 166 ++++++++++++++++
 tb/tb_game_session_ctrl.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/game_session_pkg.sv
// Shared types and helpers for the match-session controller: the session
// state encoding, field widths and the prescaler counter-width helper.
package game_session_pkg;

    localparam int STATE_W = 3;
    localparam int CD_W    = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE      = 3'd0,
        ST_COUNTDOWN = 3'd1,
        ST_RUN       = 3'd2,
        ST_PAUSED    = 3'd3,
        ST_OVER      = 3'd4
    } session_state_e;

    // Counter width able to hold 0..div-1; never narrower than one bit.
    function automatic int cnt_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/game_session_ctrl_if.sv
// Signal bundle between the session controller and its neighbours: the
// start button / score logic drive the requests, the step engine, VGA
// overlay and seven-segment timer consume the status.
interface game_session_ctrl_if
    import game_session_pkg::*;
#(
    parameter int TIME_W = 8
);

    logic               start_p;
    logic               end_req;
    logic               tie;
    logic [STATE_W-1:0] state;
    logic               frame_tick;
    logic               sec_tick;
    logic [TIME_W-1:0]  sec_left;
    logic [CD_W-1:0]    countdown;
    logic               overtime;
    logic               game_over;

    // Game-side logic: issues requests, observes the session.
    modport master (
        output start_p, end_req, tie,
        input  state, frame_tick, sec_tick, sec_left, countdown, overtime, game_over
    );

    // The session controller itself.
    modport slave (
        input  start_p, end_req, tie,
        output state, frame_tick, sec_tick, sec_left, countdown, overtime, game_over
    );

endinterface

// File: rtl/game_session_ctrl_tick_prescaler.sv
// Free-running divide-by-DIV pulse generator with enable and clear.
// tick is high for the last count of each DIV-cycle period while enabled.
module tick_prescaler
    import game_session_pkg::*;
#(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int             CW   = cnt_width(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;

    // Count while enabled, wrap at DIV-1; clr drops any partial period.
    always_ff @(posedge clk) begin
        // NOTE: reset is sampled on the clock edge, so it lives inside the
        // clocked branch rather than in the sensitivity list.
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        end
    end

    assign tick = en && (cnt_q == LAST);

endmodule

// File: rtl/game_session_ctrl.sv
// Match-session controller: sequences idle -> countdown -> run -> pause ->
// over, owns the match clock (sec_left), the resume countdown digit and the
// overtime flag, and gates the physics-step and one-second pulses.
module game_session_ctrl
    import game_session_pkg::*;
#(
    parameter int CLK_HZ        = 100_000_000,
    parameter int FRAME_HZ      = 120,
    parameter int MATCH_SEC     = 180,
    parameter int COUNTDOWN_SEC = 3,
    parameter int OT_SEC        = 30,
    parameter int TIME_W        = 8
) (
    input logic                clk,
    input logic                rst_n,
    game_session_ctrl_if.slave bus
);

    localparam int SEC_DIV   = CLK_HZ;
    localparam int FRAME_DIV = CLK_HZ / FRAME_HZ;

    localparam logic [TIME_W-1:0] MATCH_LEN = TIME_W'(MATCH_SEC);
    localparam logic [TIME_W-1:0] OT_LEN    = TIME_W'(OT_SEC);
    localparam logic [CD_W-1:0]   CD_LEN    = CD_W'(COUNTDOWN_SEC);
    localparam bit                OT_ON     = (OT_SEC > 0);

    session_state_e    state_q,     state_d;
    logic [TIME_W-1:0] sec_left_q,  sec_left_d;
    logic [CD_W-1:0]   countdown_q, countdown_d;
    logic              overtime_q,  overtime_d;

    logic sec_tick;
    logic frame_tick;
    logic sec_en;
    logic frame_en;
    logic state_chg;

    assign sec_en    = (state_q == ST_COUNTDOWN) || (state_q == ST_RUN);
    assign frame_en  = (state_q == ST_RUN);
    // Any transition restarts both prescalers so a new phase always gets
    // full-length seconds and frames.
    assign state_chg = (state_d != state_q);

    tick_prescaler #(.DIV(SEC_DIV)) u_sec_presc (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (sec_en),
        .clr   (state_chg),
        .tick  (sec_tick)
    );

    tick_prescaler #(.DIV(FRAME_DIV)) u_frame_presc (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (frame_en),
        .clr   (state_chg),
        .tick  (frame_tick)
    );

    // State and session counters register.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments here so every flop samples the
        // pre-edge values regardless of statement order.
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            sec_left_q  <= MATCH_LEN;
            countdown_q <= '0;
            overtime_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sec_left_q  <= sec_left_d;
            countdown_q <= countdown_d;
            overtime_q  <= overtime_d;
        end
    end

    // Next state plus match clock, countdown digit and overtime flag.
    always_comb begin
        // NOTE: every output of this block gets a hold default first, so no
        // branch can leave one unassigned and infer a latch.
        state_d     = state_q;
        sec_left_d  = sec_left_q;
        countdown_d = countdown_q;
        overtime_d  = overtime_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start_p) begin
                    state_d     = ST_COUNTDOWN;
                    countdown_d = CD_LEN;
                end
            end

            ST_COUNTDOWN: begin
                // A pause request beats the tick that would finish the count.
                if (bus.start_p) begin
                    state_d     = ST_PAUSED;
                    countdown_d = '0;
                end else if (sec_tick) begin
                    if (countdown_q <= CD_W'(1)) begin
                        state_d     = ST_RUN;
                        countdown_d = '0;
                    end else begin
                        countdown_d = countdown_q - CD_W'(1);
                    end
                end
            end

            ST_RUN: begin
                if (bus.end_req) begin
                    state_d = ST_OVER;
                end else if (sec_tick && (sec_left_q <= TIME_W'(1))) begin
                    // Period expired: a tied regulation match earns one
                    // overtime period, anything else ends the match.
                    sec_left_d = '0;
                    if (!overtime_q && bus.tie && OT_ON) begin
                        state_d     = ST_COUNTDOWN;
                        sec_left_d  = OT_LEN;
                        overtime_d  = 1'b1;
                        countdown_d = CD_LEN;
                    end else begin
                        state_d = ST_OVER;
                    end
                end else begin
                    if (sec_tick) begin
                        sec_left_d = sec_left_q - TIME_W'(1);
                    end
                    if (bus.start_p) begin
                        state_d = ST_PAUSED;
                    end
                end
            end

            ST_PAUSED: begin
                if (bus.start_p) begin
                    state_d     = ST_COUNTDOWN;
                    countdown_d = CD_LEN;
                end
            end

            ST_OVER: begin
                if (bus.start_p) begin
                    state_d    = ST_IDLE;
                    sec_left_d = MATCH_LEN;
                    overtime_d = 1'b0;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Drive the status bundle from registered state and the gated ticks.
    always_comb begin
        bus.state      = state_q;
        bus.sec_left   = sec_left_q;
        bus.countdown  = countdown_q;
        bus.overtime   = overtime_q;
        bus.game_over  = (state_q == ST_OVER);
        bus.sec_tick   = sec_tick;
        bus.frame_tick = frame_tick;
    end

endmodule

// File: tb/tb_game_session_ctrl.sv
// Scoreboard bench for game_session_ctrl with small parameters
// (SEC_DIV=20, FRAME_DIV=5, 3 s match, 2 s countdown, 1 s overtime).
// Expected values are queued with the cycle they are due and compared on
// the falling edge of that cycle.
module tb_game_session_ctrl;

    localparam int TIME_W = 8;

    localparam int F_STATE = 0;
    localparam int F_SECL  = 1;
    localparam int F_CD    = 2;
    localparam int F_OT    = 3;
    localparam int F_GO    = 4;
    localparam int F_FT    = 5;
    localparam int F_ST    = 6;

    typedef struct {
        int    cyc;
        int    fld;
        int    val;
        string tag;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t sb_q[$];

    game_session_ctrl_if #(.TIME_W(TIME_W)) bus ();

    game_session_ctrl #(
        .CLK_HZ        (20),
        .FRAME_HZ      (4),
        .MATCH_SEC     (3),
        .COUNTDOWN_SEC (2),
        .OT_SEC        (1),
        .TIME_W        (TIME_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0d, expected %0d", tag, cyc, act, exp);
        end
    endtask

    function automatic int get_field(input int f);
        case (f)
            F_STATE: return int'(bus.state);
            F_SECL:  return int'(bus.sec_left);
            F_CD:    return int'(bus.countdown);
            F_OT:    return int'(bus.overtime);
            F_GO:    return int'(bus.game_over);
            F_FT:    return int'(bus.frame_tick);
            F_ST:    return int'(bus.sec_tick);
            default: return -1;
        endcase
    endfunction

    task automatic exp_at(input int c, input int f, input int v, input string tag);
        sb_q.push_back('{cyc: c, fld: f, val: v, tag: tag});
    endtask

    // Scoreboard: compare every entry due this cycle, then retire it.
    always @(negedge clk) begin
        for (int i = sb_q.size() - 1; i >= 0; i--) begin
            if (sb_q[i].cyc == cyc) begin
                check(sb_q[i].tag, get_field(sb_q[i].fld), sb_q[i].val);
                sb_q.delete(i);
            end
        end
    end

    task automatic goto(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic pulse_start();
        bus.start_p = 1'b1;
        @(negedge clk);
        bus.start_p = 1'b0;
    endtask

    initial begin
        int t;
        int guard;

        rst_n       = 1'b0;
        bus.start_p = 1'b0;
        bus.end_req = 1'b0;
        bus.tie     = 1'b0;
        repeat (3) @(negedge clk);

        // Reset values.
        t = cyc;
        exp_at(t + 1, F_STATE, 0, "rst_state");
        exp_at(t + 1, F_SECL,  3, "rst_sec_left");
        exp_at(t + 1, F_CD,    0, "rst_countdown");
        exp_at(t + 1, F_OT,    0, "rst_overtime");
        exp_at(t + 1, F_GO,    0, "rst_game_over");
        exp_at(t + 1, F_FT,    0, "rst_frame_tick");
        exp_at(t + 1, F_ST,    0, "rst_sec_tick");
        rst_n = 1'b1;

        // Full regulation match with no tie: start at t, run at t+41, over at t+101.
        goto(t + 5);
        t = cyc;
        exp_at(t + 1,   F_STATE, 1, "m1_countdown_entry");
        exp_at(t + 1,   F_CD,    2, "m1_cd_load");
        exp_at(t + 19,  F_ST,    0, "m1_no_early_sec_tick");
        exp_at(t + 20,  F_ST,    1, "m1_first_sec_tick");
        exp_at(t + 20,  F_CD,    2, "m1_cd_before_tick");
        exp_at(t + 21,  F_CD,    1, "m1_cd_after_tick");
        exp_at(t + 40,  F_STATE, 1, "m1_still_countdown");
        exp_at(t + 41,  F_STATE, 2, "m1_run_entry");
        exp_at(t + 41,  F_CD,    0, "m1_cd_zero_in_run");
        exp_at(t + 44,  F_FT,    0, "m1_no_early_frame");
        exp_at(t + 45,  F_FT,    1, "m1_frame_1");
        exp_at(t + 46,  F_FT,    0, "m1_frame_1_single");
        exp_at(t + 50,  F_FT,    1, "m1_frame_2");
        exp_at(t + 55,  F_FT,    1, "m1_frame_3");
        exp_at(t + 60,  F_SECL,  3, "m1_secl_3");
        exp_at(t + 61,  F_SECL,  2, "m1_secl_2");
        exp_at(t + 81,  F_SECL,  1, "m1_secl_1");
        exp_at(t + 100, F_STATE, 2, "m1_run_last");
        exp_at(t + 100, F_GO,    0, "m1_not_over_yet");
        exp_at(t + 101, F_SECL,  0, "m1_secl_0");
        exp_at(t + 101, F_STATE, 4, "m1_over");
        exp_at(t + 101, F_GO,    1, "m1_game_over");
        exp_at(t + 101, F_OT,    0, "m1_no_overtime");
        exp_at(t + 104, F_FT,    0, "m1_no_frame_in_over");
        exp_at(t + 105, F_SECL,  0, "m1_secl_held");
        exp_at(t + 106, F_STATE, 0, "m1_back_idle");
        exp_at(t + 106, F_SECL,  3, "m1_secl_reload");
        exp_at(t + 106, F_GO,    0, "m1_game_over_clr");
        pulse_start();
        goto(t + 105);
        pulse_start();

        // Pause at sec_left=2, 100 frozen cycles, resume, then tied timeout
        // into one overtime period which ends the match despite a second tie.
        goto(t + 110);
        t = cyc;
        exp_at(t + 41,  F_STATE, 2, "m2_run_entry");
        exp_at(t + 65,  F_SECL,  2, "m2_secl_before_pause");
        exp_at(t + 66,  F_STATE, 3, "m2_paused");
        for (int k = 66; k < 166; k++) begin
            exp_at(t + k, F_FT,   0, "m2_pause_no_frame");
            exp_at(t + k, F_ST,   0, "m2_pause_no_sec");
            exp_at(t + k, F_SECL, 2, "m2_pause_secl_frozen");
        end
        exp_at(t + 101, F_STATE, 3, "m2_end_req_ignored");
        exp_at(t + 165, F_STATE, 3, "m2_still_paused");
        exp_at(t + 167, F_STATE, 1, "m2_resume_countdown");
        exp_at(t + 167, F_CD,    2, "m2_resume_cd_load");
        exp_at(t + 206, F_STATE, 1, "m2_resume_cd_last");
        exp_at(t + 207, F_STATE, 2, "m2_resume_run");
        exp_at(t + 207, F_SECL,  2, "m2_resume_secl");
        exp_at(t + 211, F_FT,    1, "m2_resume_frame");
        exp_at(t + 227, F_SECL,  1, "m2_secl_1");
        exp_at(t + 246, F_STATE, 2, "m2_run_before_timeout");
        exp_at(t + 247, F_STATE, 1, "m3_ot_countdown");
        exp_at(t + 247, F_OT,    1, "m3_ot_flag");
        exp_at(t + 247, F_SECL,  1, "m3_ot_secl");
        exp_at(t + 247, F_CD,    2, "m3_ot_cd_load");
        exp_at(t + 267, F_CD,    1, "m3_ot_cd_1");
        exp_at(t + 287, F_STATE, 2, "m3_ot_run");
        exp_at(t + 290, F_OT,    1, "m3_ot_flag_held");
        exp_at(t + 306, F_ST,    1, "m3_ot_sec_tick");
        exp_at(t + 307, F_STATE, 4, "m3_ot_over");
        exp_at(t + 307, F_SECL,  0, "m3_ot_secl_0");
        exp_at(t + 307, F_GO,    1, "m3_ot_game_over");
        exp_at(t + 311, F_STATE, 0, "m3_idle");
        exp_at(t + 311, F_OT,    0, "m3_ot_cleared");
        exp_at(t + 311, F_SECL,  3, "m3_secl_reload");
        pulse_start();
        goto(t + 65);
        pulse_start();
        goto(t + 100);
        bus.end_req = 1'b1;
        @(negedge clk);
        bus.end_req = 1'b0;
        goto(t + 166);
        pulse_start();
        goto(t + 230);
        bus.tie = 1'b1;
        goto(t + 310);
        bus.tie = 1'b0;
        pulse_start();

        // end_req and start_p together in RUN: end_req wins.
        goto(t + 315);
        t = cyc;
        exp_at(t + 50, F_STATE, 2, "m4_run");
        exp_at(t + 51, F_STATE, 4, "m4_end_beats_pause");
        exp_at(t + 51, F_GO,    1, "m4_game_over");
        exp_at(t + 56, F_STATE, 0, "m4_idle");
        pulse_start();
        goto(t + 50);
        bus.end_req = 1'b1;
        pulse_start();
        bus.end_req = 1'b0;
        goto(t + 55);
        pulse_start();

        // Pause on the completing countdown tick, reload on resume, then
        // reset during RUN with sec_left=1.
        goto(t + 60);
        t = cyc;
        exp_at(t + 40,  F_ST,    1, "m5_completing_tick");
        exp_at(t + 41,  F_STATE, 3, "m5_pause_beats_tick");
        exp_at(t + 41,  F_CD,    0, "m5_cd_zero_paused");
        exp_at(t + 46,  F_STATE, 1, "m5_resume_countdown");
        exp_at(t + 46,  F_CD,    2, "m5_cd_reload");
        exp_at(t + 86,  F_STATE, 2, "m5_run");
        exp_at(t + 86,  F_SECL,  3, "m5_secl_full");
        exp_at(t + 130, F_SECL,  1, "m6_secl_1");
        exp_at(t + 131, F_STATE, 0, "m6_rst_state");
        exp_at(t + 131, F_SECL,  3, "m6_rst_secl");
        exp_at(t + 131, F_OT,    0, "m6_rst_overtime");
        exp_at(t + 131, F_CD,    0, "m6_rst_countdown");
        exp_at(t + 131, F_FT,    0, "m6_rst_frame_tick");
        exp_at(t + 131, F_ST,    0, "m6_rst_sec_tick");
        exp_at(t + 154, F_ST,    0, "m6_presc_clear_early");
        exp_at(t + 155, F_ST,    1, "m6_presc_clear_tick");
        pulse_start();
        goto(t + 40);
        pulse_start();
        goto(t + 45);
        pulse_start();
        goto(t + 130);
        rst_n       = 1'b0;
        bus.start_p = 1'b1;
        bus.end_req = 1'b1;
        bus.tie     = 1'b1;
        @(negedge clk);
        rst_n       = 1'b1;
        bus.start_p = 1'b0;
        bus.end_req = 1'b0;
        bus.tie     = 1'b0;
        goto(t + 135);
        pulse_start();

        // Drain the scoreboard with a bounded wait.
        guard = 0;
        while (sb_q.size() > 0 && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        foreach (sb_q[i]) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: expected %0d at cyc %0d, never compared", sb_q[i].tag,
                     sb_q[i].val, sb_q[i].cyc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
